// File: rtl/i2s_line_in_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_line_in_rx_if
// Description : Codec-side serial pins and parallel sample outputs of the
//               I2S line-in receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_line_in_rx_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  enable;
    logic                  i2s_bclk;
    logic                  i2s_lrclk;
    logic                  i2s_sdata;
    logic [DATA_WIDTH-1:0] sample_left;
    logic [DATA_WIDTH-1:0] sample_right;
    logic                  sample_valid;
    logic                  frame_err;

    modport master (
        output enable, i2s_bclk, i2s_lrclk, i2s_sdata,
        input  sample_left, sample_right, sample_valid, frame_err
    );

    modport slave (
        input  enable, i2s_bclk, i2s_lrclk, i2s_sdata,
        output sample_left, sample_right, sample_valid, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/i2s_line_in_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_line_in_rx
// Description : Oversampling I2S receiver; delivers 24-bit L/R pairs in the
//               system clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_line_in_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    i2s_line_in_rx_if.slave  bus
);
    localparam int                 c_CNT_W    = $clog2(SLOT_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_DW_CNT   = c_CNT_W'(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_DW_LAST  = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_CNT = c_CNT_W'(SLOT_WIDTH);

    logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic r_lrclk_s1, r_lrclk_s2, r_lrclk_s3;
    logic r_sdata_s1, r_sdata_s2, r_sdata_s3;
    logic r_rise;

    logic                  r_lr_last;
    logic                  r_lr_known;
    logic                  r_arm_n;
    logic                  r_cur_ch;
    logic                  r_have_left;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic [DATA_WIDTH-1:0] r_sample_left;
    logic [DATA_WIDTH-1:0] r_sample_right;
    logic                  r_sample_valid;
    logic                  r_frame_err;

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_lr_change;
    logic                  w_partial;

    // Third stage delays lrclk/sdata with bclk so the registered rise sees aligned data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk_s1  <= 1'b0;
            r_bclk_s2  <= 1'b0;
            r_bclk_s3  <= 1'b0;
            r_lrclk_s1 <= 1'b0;
            r_lrclk_s2 <= 1'b0;
            r_lrclk_s3 <= 1'b0;
            r_sdata_s1 <= 1'b0;
            r_sdata_s2 <= 1'b0;
            r_sdata_s3 <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_bclk_s1  <= bus.i2s_bclk;
            r_bclk_s2  <= r_bclk_s1;
            r_bclk_s3  <= r_bclk_s2;
            r_lrclk_s1 <= bus.i2s_lrclk;
            r_lrclk_s2 <= r_lrclk_s1;
            r_lrclk_s3 <= r_lrclk_s2;
            r_sdata_s1 <= bus.i2s_sdata;
            r_sdata_s2 <= r_sdata_s1;
            r_sdata_s3 <= r_sdata_s2;
            r_rise     <= r_bclk_s2 & ~r_bclk_s3;
        end
    end

    assign w_word      = {r_shift, r_sdata_s3};
    // The first rise after reset only establishes the reference lrclk level
    assign w_lr_change = r_lr_known && (r_lrclk_s3 != r_lr_last);
    assign w_partial   = (r_bit_cnt != '0) && (r_bit_cnt < c_DW_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lr_last      <= 1'b0;
            r_lr_known     <= 1'b0;
            r_arm_n        <= 1'b1;
            r_cur_ch       <= 1'b0;
            r_have_left    <= 1'b0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_left_hold    <= '0;
            r_sample_left  <= '0;
            r_sample_right <= '0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;

            if (!bus.enable) begin
                r_have_left <= 1'b0;
                r_arm_n     <= 1'b1;
            end

            if (r_rise) begin
                r_lr_last  <= r_lrclk_s3;
                r_lr_known <= 1'b1;
                if (bus.enable) begin
                    if (w_lr_change) begin
                        // The bit at the lrclk edge belongs to the previous word
                        if (!r_arm_n && w_partial) begin
                            r_frame_err <= 1'b1;
                            r_have_left <= 1'b0;
                        end
                        r_bit_cnt <= '0;
                        r_cur_ch  <= r_lrclk_s3;
                        r_arm_n   <= 1'b0;
                    end else if (!r_arm_n) begin
                        if (r_bit_cnt < c_DW_CNT) begin
                            r_shift   <= w_word[DATA_WIDTH-2:0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_DW_LAST) begin
                                if (!r_cur_ch) begin
                                    r_left_hold <= w_word;
                                    r_have_left <= 1'b1;
                                end else if (r_have_left) begin
                                    r_sample_left  <= r_left_hold;
                                    r_sample_right <= w_word;
                                    r_sample_valid <= 1'b1;
                                    r_have_left    <= 1'b0;
                                end
                            end
                        end else if (r_bit_cnt < c_SLOT_CNT) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.sample_left  = r_sample_left;
    assign bus.sample_right = r_sample_right;
    assign bus.sample_valid = r_sample_valid;
    assign bus.frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_line_in_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_line_in_rx
// Description : Randomised I2S stream against a word-level model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_line_in_rx;
    localparam int DW   = 24;
    localparam int SW   = 32;
    localparam int HALF = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_line_in_rx_if #(.DATA_WIDTH(DW)) bus();

    i2s_line_in_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            at;
    } exp_t;
    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endfunction

    // Word-level model of the receiver
    bit            m_known, m_last, m_armed, m_have_left, m_cur, m_en;
    int            m_cnt;
    logic [DW-1:0] m_left;
    logic [DW-1:0] held_l, held_r;

    function automatic void model_reset();
        m_known = 0; m_last = 0; m_armed = 0; m_have_left = 0; m_cur = 0; m_cnt = 0;
    endfunction

    task automatic drive_bit(input bit lr, input bit d, output int rc);
        @(negedge clk);
        bus.i2s_bclk = 1'b0; bus.i2s_lrclk = lr; bus.i2s_sdata = d;
        repeat (HALF-1) @(negedge clk);
        bus.i2s_bclk = 1'b1;
        rc = cyc;
        repeat (HALF-1) @(negedge clk);
    endtask

    // Slot layout: bit 0 at the lrclk level change, bits 1..DW the word MSB first, then padding
    task automatic send_word(input bit ch, input logic [DW-1:0] data, input int total, input bit pad);
        bit change;
        int avail;
        int done_idx;
        int rc;
        bit b;
        change   = m_known && (ch != m_last);
        m_known  = 1;
        m_last   = ch;
        done_idx = -1;
        if (m_en) begin
            if (change) begin
                if (m_armed && m_cnt > 0 && m_cnt < DW) begin
                    exp_q.push_back('{is_err: 1'b1, l: '0, r: '0, at: 0});
                    m_have_left = 0;
                end
                m_armed = 1; m_cnt = 0; m_cur = ch;
            end
            if (m_armed) begin
                avail = change ? total - 1 : total;
                if (m_cnt < DW && m_cnt + avail >= DW)
                    done_idx = (change ? 1 : 0) + (DW - m_cnt) - 1;
                m_cnt = (m_cnt + avail > SW) ? SW : m_cnt + avail;
            end
        end
        for (int i = 0; i < total; i++) begin
            if (i >= 1 && i <= DW) b = data[DW-i];
            else if (i == 0)       b = 1'($urandom_range(0, 1));
            else                   b = pad;
            drive_bit(ch, b, rc);
            if (i == done_idx) begin
                if (!m_cur) begin
                    m_left = data; m_have_left = 1;
                end else if (m_have_left) begin
                    exp_q.push_back('{is_err: 1'b0, l: m_left, r: data, at: rc + 4});
                    m_have_left = 0;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int len_l, input int len_r, input bit pad);
        send_word(1'b0, l, len_l, pad);
        send_word(1'b1, r, len_r, pad);
    endtask

    task automatic set_en(input bit v);
        repeat (8) @(negedge clk);
        bus.enable = v;
        m_en = v;
        if (!v) begin m_armed = 0; m_have_left = 0; end
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            held_l = '0; held_r = '0;
        end else if (bus.sample_valid || bus.frame_err) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_pulse", {bus.sample_valid, bus.frame_err}, 0);
            end else begin
                e = exp_q.pop_front();
                check({bus.sample_valid, bus.frame_err} == {~e.is_err, e.is_err}, "pulse_kind",
                      {bus.sample_valid, bus.frame_err}, {~e.is_err, e.is_err});
                if (!e.is_err) begin
                    check(bus.sample_left == e.l, "sample_left", bus.sample_left, e.l);
                    check(bus.sample_right == e.r, "sample_right", bus.sample_right, e.r);
                    check(cyc == e.at, "valid_latency", cyc, e.at);
                    held_l = e.l; held_r = e.r;
                end
            end
        end else begin
            check(bus.sample_left == held_l && bus.sample_right == held_r, "output_hold",
                  {bus.sample_left, bus.sample_right}, {held_l, held_r});
        end
    end

    initial begin
        bus.enable = 1'b1; bus.i2s_bclk = 1'b0; bus.i2s_lrclk = 1'b0; bus.i2s_sdata = 1'b0;
        m_en = 1; model_reset();
        repeat (4) @(negedge clk);
        check(bus.sample_left == '0, "reset_left", bus.sample_left, 0);
        check(bus.sample_right == '0, "reset_right", bus.sample_right, 0);
        check(bus.sample_valid == 1'b0, "reset_valid", bus.sample_valid, 0);
        check(bus.frame_err == 1'b0, "reset_err", bus.frame_err, 0);
        rst_n = 1'b1;

        // Stream starts in the middle of a right word
        send_word(1'b1, rnd(), 13, 1'b0);
        repeat (2) send_frame(24'hABCDEF, 24'h123456, SW, SW, 1'b0);
        repeat (4) send_frame(rnd(), rnd(), SW, SW, 1'($urandom_range(0, 1)));

        // Left word cut short after 10 bits
        send_word(1'b0, rnd(), 11, 1'b0);
        send_word(1'b1, rnd(), SW, 1'b0);
        send_frame(24'h800000, 24'h7FFFFF, SW, SW, 1'b0);

        // Asynchronous reset in the middle of a left word
        send_frame(24'hABCDEF, 24'h123456, SW, SW, 1'b0);
        send_word(1'b0, rnd(), 12, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check(bus.sample_left == '0, "async_reset_left", bus.sample_left, 0);
        check(bus.sample_right == '0, "async_reset_right", bus.sample_right, 0);
        check(bus.sample_valid == 1'b0, "async_reset_valid", bus.sample_valid, 0);
        check(exp_q.size() == 0, "pending_at_reset", exp_q.size(), 0);
        model_reset();
        bus.i2s_bclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_word(1'b0, rnd(), 10, 1'b0);
        send_word(1'b1, rnd(), SW, 1'b0);
        send_frame(rnd(), rnd(), SW, SW, 1'b0);

        // Padding bits all ones
        repeat (2) send_frame(24'h000001, 24'hFFFFFE, SW, SW, 1'b1);

        // Enable dropped for three frames
        send_frame(rnd(), rnd(), SW, SW, 1'b0);
        set_en(1'b0);
        repeat (3) send_frame(rnd(), rnd(), SW, SW, 1'($urandom_range(0, 1)));
        set_en(1'b1);
        repeat (3) send_frame(rnd(), rnd(), SW, SW, 1'($urandom_range(0, 1)));

        // Random slot lengths
        repeat (8) send_frame(rnd(), rnd(), int'($urandom_range(DW + 1, SW)),
                              int'($urandom_range(DW + 1, SW)), 1'($urandom_range(0, 1)));

        repeat (40) @(negedge clk);
        check(exp_q.size() == 0, "missing_outputs", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
